// File: rtl/pipe_pkg.sv
// pipe_pkg: shared opcodes, scoreboard entry type and ID stage state encoding
// for the decode/interlock stage.
//   OP_*         opcodes recognised by the decoder (IR[31:26])
//   sb_entry_t   one destination-scoreboard slot {valid, is_load, dest}
//   SB_BUBBLE    empty scoreboard slot
//   stage_state_e RUN / STALL / FLUSH
package pipe_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LOAD  = 6'h23;
    localparam logic [5:0] OP_STORE = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    typedef struct packed {
        logic       valid;
        logic       is_load;
        logic [4:0] dest;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '{valid: 1'b0, is_load: 1'b0, dest: 5'd0};

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STALL,
        ST_FLUSH
    } stage_state_e;

endpackage

// File: rtl/instr_field_decode.sv
// instr_field_decode: purely combinational field extraction for one instruction.
//   ir_i           instruction word
//   rs_o/rt_o/rd_o register fields
//   imm_o          sign-extended IR[15:0]
//   src_rs_used_o  instruction reads rs
//   src_rt_used_o  instruction reads rt
//   dest_o         destination register (rd for R-type, rt for load/addi)
//   dest_valid_o   instruction writes a non-zero register
//   is_load_o      instruction is a load
module instr_field_decode
    import pipe_pkg::*;
(
    input  logic [31:0] ir_i,
    output logic [4:0]  rs_o,
    output logic [4:0]  rt_o,
    output logic [4:0]  rd_o,
    output logic [31:0] imm_o,
    output logic        src_rs_used_o,
    output logic        src_rt_used_o,
    output logic [4:0]  dest_o,
    output logic        dest_valid_o,
    output logic        is_load_o
);

    logic [5:0] op;
    logic       has_dest;

    always_comb begin
        op            = ir_i[31:26];
        rs_o          = ir_i[25:21];
        rt_o          = ir_i[20:16];
        rd_o          = ir_i[15:11];
        imm_o         = {{16{ir_i[15]}}, ir_i[15:0]};
        src_rs_used_o = 1'b0;
        src_rt_used_o = 1'b0;
        dest_o        = 5'd0;
        has_dest      = 1'b0;
        is_load_o     = 1'b0;

        case (op)
            OP_RTYPE: begin
                src_rs_used_o = 1'b1;
                src_rt_used_o = 1'b1;
                dest_o        = ir_i[15:11];
                has_dest      = 1'b1;
            end
            OP_STORE, OP_BEQ: begin
                src_rs_used_o = 1'b1;
                src_rt_used_o = 1'b1;
            end
            OP_LOAD: begin
                src_rs_used_o = 1'b1;
                dest_o        = ir_i[20:16];
                has_dest      = 1'b1;
                is_load_o     = 1'b1;
            end
            OP_ADDI: begin
                src_rs_used_o = 1'b1;
                dest_o        = ir_i[20:16];
                has_dest      = 1'b1;
            end
            default: ;
        endcase

        // r0 is hardwired, so a write to it never creates a dependency
        dest_valid_o = has_dest && (dest_o != 5'd0);
    end

endmodule

// File: rtl/id_interlock_stage.sv
// id_interlock_stage: IF/ID register, decode, and RAW interlock against a
// two-deep destination scoreboard (EX, MEM). Branches resolved in EX flush ID.
//   clk, reset                      clock (posedge), synchronous active-high reset
//   inputIR, inputPC                instruction/PC from fetch
//   ex_branch_taken/target          branch resolution from EX
//   isDataInterLock                 hold fetch and ID (combinational)
//   is_Branch_Taken, branchPC       fetch redirect (pass-through)
//   id_IR, id_PC                    IF/ID register contents
//   id_rs, id_rt, id_rd, id_imm     decoded fields of id_IR
//   ex_valid                        ID instruction issues to EX this cycle
//   stall_count                     saturating interlock-cycle count
module id_interlock_stage
    import pipe_pkg::*;
#(
    parameter int unsigned FORWARDING  = 1,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            inputIR,
    input  logic [31:0]            inputPC,
    input  logic                   ex_branch_taken,
    input  logic [31:0]            ex_branch_target,
    output logic                   isDataInterLock,
    output logic                   is_Branch_Taken,
    output logic [31:0]            branchPC,
    output logic [31:0]            id_IR,
    output logic [31:0]            id_PC,
    output logic [4:0]             id_rs,
    output logic [4:0]             id_rt,
    output logic [4:0]             id_rd,
    output logic [31:0]            id_imm,
    output logic                   ex_valid,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic USE_FWD = (FORWARDING != 0);

    logic                   id_valid_q, id_valid_d;
    logic [31:0]            id_ir_q, id_ir_d;
    logic [31:0]            id_pc_q, id_pc_d;
    sb_entry_t              sb_ex_q, sb_ex_d;
    sb_entry_t              sb_mem_q, sb_mem_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    stage_state_e           state_q, state_d;

    logic       dec_rs_used, dec_rt_used, dec_dest_valid, dec_is_load;
    logic [4:0] dec_dest;
    logic       hazard;
    sb_entry_t  issue_entry;

    instr_field_decode u_decode (
        .ir_i          (id_ir_q),
        .rs_o          (id_rs),
        .rt_o          (id_rt),
        .rd_o          (id_rd),
        .imm_o         (id_imm),
        .src_rs_used_o (dec_rs_used),
        .src_rt_used_o (dec_rt_used),
        .dest_o        (dec_dest),
        .dest_valid_o  (dec_dest_valid),
        .is_load_o     (dec_is_load)
    );

    // A source conflicts with a scoreboard slot when it names that slot's
    // destination; with forwarding only a load still in EX cannot be bypassed.
    function automatic logic src_conflict(input logic used, input logic [4:0] r,
                                          input sb_entry_t ex_e, input sb_entry_t mem_e);
        logic ex_hit, mem_hit;
        ex_hit  = ex_e.valid && (ex_e.dest == r);
        mem_hit = mem_e.valid && (mem_e.dest == r);
        if (!used || (r == 5'd0)) begin
            return 1'b0;
        end
        if (USE_FWD) begin
            return ex_hit && ex_e.is_load;
        end
        return ex_hit || mem_hit;
    endfunction

    always_comb begin
        hazard = id_valid_q &&
                 (src_conflict(dec_rs_used, id_rs, sb_ex_q, sb_mem_q) ||
                  src_conflict(dec_rt_used, id_rt, sb_ex_q, sb_mem_q));
    end

    assign isDataInterLock = hazard && !ex_branch_taken;
    assign ex_valid        = id_valid_q && !hazard && !ex_branch_taken;
    assign is_Branch_Taken = ex_branch_taken;
    assign branchPC        = ex_branch_target;
    assign id_IR           = id_ir_q;
    assign id_PC           = id_pc_q;
    assign stall_count     = stall_cnt_q;

    always_comb begin
        issue_entry         = SB_BUBBLE;
        issue_entry.valid   = id_valid_q && dec_dest_valid;
        issue_entry.is_load = dec_is_load;
        issue_entry.dest    = dec_dest;
    end

    always_comb begin
        id_valid_d  = id_valid_q;
        id_ir_d     = id_ir_q;
        id_pc_d     = id_pc_q;
        sb_ex_d     = sb_ex_q;
        sb_mem_d    = sb_mem_q;
        stall_cnt_d = stall_cnt_q;
        state_d     = state_q;

        if (ex_branch_taken) begin
            id_valid_d = 1'b0;
            sb_ex_d    = SB_BUBBLE;
            sb_mem_d   = sb_ex_q;
            state_d    = ST_FLUSH;
        end else if (hazard) begin
            // Bubble enters EX every stalled cycle, so the scoreboard drains
            // and the stall ends without an explicit exit condition.
            sb_ex_d  = SB_BUBBLE;
            sb_mem_d = sb_ex_q;
            if (stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
            end
            state_d = ST_STALL;
        end else begin
            id_valid_d = 1'b1;
            id_ir_d    = inputIR;
            id_pc_d    = inputPC;
            sb_ex_d    = issue_entry;
            sb_mem_d   = sb_ex_q;
            state_d    = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_valid_q  <= 1'b0;
            id_ir_q     <= '0;
            id_pc_q     <= '0;
            sb_ex_q     <= SB_BUBBLE;
            sb_mem_q    <= SB_BUBBLE;
            stall_cnt_q <= '0;
            state_q     <= ST_RUN;
        end else begin
            id_valid_q  <= id_valid_d;
            id_ir_q     <= id_ir_d;
            id_pc_q     <= id_pc_d;
            sb_ex_q     <= sb_ex_d;
            sb_mem_q    <= sb_mem_d;
            stall_cnt_q <= stall_cnt_d;
            state_q     <= state_d;
        end
    end

endmodule

// File: tb/tb_id_interlock_stage.sv
// Bench for id_interlock_stage: three instances (forwarding, no forwarding,
// 2-bit saturating counter) share one stimulus stream; each is checked every
// cycle against an instruction-level model plus directed literal checks.
module tb_id_interlock_stage;

    logic        clk;
    logic        reset;
    logic [31:0] inputIR, inputPC, ex_branch_target;
    logic        ex_branch_taken;

    logic        dil [3];
    logic        ibt [3];
    logic [31:0] bpc [3];
    logic [31:0] idir [3];
    logic [31:0] idpc [3];
    logic [4:0]  rs [3];
    logic [4:0]  rt [3];
    logic [4:0]  rd [3];
    logic [31:0] imm [3];
    logic        exv [3];
    logic [15:0] sc0, sc1;
    logic [1:0]  sc2;

    int n_tests = 0;
    int n_fail  = 0;

    id_interlock_stage #(.FORWARDING(1), .STALL_CNT_W(16)) u_fwd (
        .clk(clk), .reset(reset), .inputIR(inputIR), .inputPC(inputPC),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .isDataInterLock(dil[0]), .is_Branch_Taken(ibt[0]), .branchPC(bpc[0]),
        .id_IR(idir[0]), .id_PC(idpc[0]), .id_rs(rs[0]), .id_rt(rt[0]), .id_rd(rd[0]),
        .id_imm(imm[0]), .ex_valid(exv[0]), .stall_count(sc0));

    id_interlock_stage #(.FORWARDING(0), .STALL_CNT_W(16)) u_nofwd (
        .clk(clk), .reset(reset), .inputIR(inputIR), .inputPC(inputPC),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .isDataInterLock(dil[1]), .is_Branch_Taken(ibt[1]), .branchPC(bpc[1]),
        .id_IR(idir[1]), .id_PC(idpc[1]), .id_rs(rs[1]), .id_rt(rt[1]), .id_rd(rd[1]),
        .id_imm(imm[1]), .ex_valid(exv[1]), .stall_count(sc1));

    id_interlock_stage #(.FORWARDING(1), .STALL_CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .inputIR(inputIR), .inputPC(inputPC),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .isDataInterLock(dil[2]), .is_Branch_Taken(ibt[2]), .branchPC(bpc[2]),
        .id_IR(idir[2]), .id_PC(idpc[2]), .id_rs(rs[2]), .id_rt(rt[2]), .id_rd(rd[2]),
        .id_imm(imm[2]), .ex_valid(exv[2]), .stall_count(sc2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Per instance: the instruction sitting in ID, and the instruction words
    // that entered EX one and two cycles ago (hv=0 marks a bubble).
    bit          fwd [3] = '{1'b1, 1'b0, 1'b1};
    int unsigned cap [3] = '{65535, 65535, 3};
    bit          m_idv [3];
    bit [31:0]   m_ir [3];
    bit [31:0]   m_pc [3];
    bit          m_hv [3][2];
    bit [31:0]   m_hir [3][2];
    int unsigned m_cnt [3];

    function automatic int mdest(input bit [31:0] ir);
        int d;
        case (ir[31:26])
            6'h00:        d = int'(ir[15:11]);
            6'h08, 6'h23: d = int'(ir[20:16]);
            default:      d = 0;
        endcase
        return (d == 0) ? -1 : d;
    endfunction

    function automatic bit mreads(input bit [31:0] ir, input int r);
        int s1, s2;
        s1 = int'(ir[25:21]);
        s2 = int'(ir[20:16]);
        if (r <= 0) return 1'b0;
        case (ir[31:26])
            6'h00, 6'h2B, 6'h04: return (s1 == r) || (s2 == r);
            6'h08, 6'h23:        return (s1 == r);
            default:             return 1'b0;
        endcase
    endfunction

    function automatic bit m_hazard(input int i);
        bit h;
        h = 1'b0;
        if (!m_idv[i]) return 1'b0;
        for (int k = 0; k < (fwd[i] ? 1 : 2); k++) begin
            if (m_hv[i][k] && mreads(m_ir[i], mdest(m_hir[i][k])) &&
                (!fwd[i] || m_hir[i][k][31:26] == 6'h23))
                h = 1'b1;
        end
        return h;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            bit hz;
            hz = m_hazard(i);
            if (reset) begin
                m_idv[i] = 1'b0; m_ir[i] = '0; m_pc[i] = '0; m_cnt[i] = 0;
                m_hv[i][0] = 1'b0; m_hv[i][1] = 1'b0;
            end else begin
                m_hv[i][1]  = m_hv[i][0];
                m_hir[i][1] = m_hir[i][0];
                if (ex_branch_taken) begin
                    m_hv[i][0] = 1'b0;
                    m_idv[i]   = 1'b0;
                end else if (hz) begin
                    m_hv[i][0] = 1'b0;
                    if (m_cnt[i] < cap[i]) m_cnt[i] = m_cnt[i] + 1;
                end else begin
                    m_hv[i][0]  = m_idv[i];
                    m_hir[i][0] = m_ir[i];
                    m_ir[i]     = inputIR;
                    m_pc[i]     = inputPC;
                    m_idv[i]    = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d t=%0t actual=%h expected=%h", name, inst, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] sc_of(input int i);
        case (i)
            0:       return 32'(sc0);
            1:       return 32'(sc1);
            default: return 32'(sc2);
        endcase
    endfunction

    // Compare process: all outputs of all instances, every cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            bit hz;
            hz = m_hazard(i);
            chk("interlock", i, 32'(dil[i]), 32'(hz && !ex_branch_taken));
            chk("ex_valid",  i, 32'(exv[i]), 32'(m_idv[i] && !hz && !ex_branch_taken));
            chk("br_taken",  i, 32'(ibt[i]), 32'(ex_branch_taken));
            chk("branchPC",  i, bpc[i], ex_branch_target);
            chk("id_IR",     i, idir[i], m_ir[i]);
            chk("id_PC",     i, idpc[i], m_pc[i]);
            chk("id_rs",     i, 32'(rs[i]), 32'(m_ir[i] >> 21) & 32'h1F);
            chk("id_rt",     i, 32'(rt[i]), 32'(m_ir[i] >> 16) & 32'h1F);
            chk("id_rd",     i, 32'(rd[i]), 32'(m_ir[i] >> 11) & 32'h1F);
            chk("id_imm",    i, imm[i], 32'($signed(m_ir[i][15:0])));
            chk("stall_cnt", i, sc_of(i), 32'(m_cnt[i]));
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] pcv = 32'h100;

    function automatic logic [31:0] enc_r(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d);
        return {6'h00, s, t, d, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    task automatic step(input logic [31:0] ir, input logic bt, input logic [31:0] tgt,
                        input logic rst);
        @(posedge clk);
        #1;
        inputIR = ir; inputPC = pcv; ex_branch_taken = bt;
        ex_branch_target = tgt; reset = rst;
        pcv = pcv + 4;
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ir);
        step(ir, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic pad(input int n);
        for (int k = 0; k < n; k++) issue(32'h0);
    endtask

    logic [31:0] LW5, ADD6, ADD3, SUB4;
    logic [31:0] pc_mark;

    initial begin
        reset = 1'b1; inputIR = '0; inputPC = '0;
        ex_branch_taken = 1'b0; ex_branch_target = '0;
        LW5  = enc_i(6'h23, 5'd1, 5'd5, 16'h0000);
        ADD6 = enc_r(5'd5, 5'd7, 5'd6);
        ADD3 = enc_r(5'd1, 5'd2, 5'd3);
        SUB4 = {6'h00, 5'd3, 5'd1, 5'd4, 5'd0, 6'h22};

        step(32'h0, 1'b0, 32'h0, 1'b1);
        step(32'h0, 1'b0, 32'h0, 1'b1);
        issue(32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("rst_dil", i, 32'(dil[i]), 32'd0);
            chk("rst_exv", i, 32'(exv[i]), 32'd0);
            chk("rst_cnt", i, sc_of(i), 32'd0);
        end
        pad(2);

        // load-use with forwarding: one interlock cycle
        issue(LW5);
        pc_mark = pcv;
        issue(ADD6);
        issue(32'h0);
        chk("lu_dil_c1", 0, 32'(dil[0]), 32'd1);
        chk("lu_exv_c1", 0, 32'(exv[0]), 32'd0);
        issue(32'h0);
        chk("lu_dil_c2", 0, 32'(dil[0]), 32'd0);
        chk("lu_exv_c2", 0, 32'(exv[0]), 32'd1);
        chk("lu_pc",     0, idpc[0], pc_mark);
        chk("lu_cnt",    0, sc_of(0), 32'd1);
        pad(3);

        // ALU RAW without forwarding: two interlock cycles, sub held in ID
        issue(ADD3);
        pc_mark = pcv;
        issue(SUB4);
        issue(32'h0);
        chk("raw_dil_c1", 1, 32'(dil[1]), 32'd1);
        chk("raw_pc_c1",  1, idpc[1], pc_mark);
        chk("raw_fwd_c1", 0, 32'(dil[0]), 32'd0);
        issue(32'h0);
        chk("raw_dil_c2", 1, 32'(dil[1]), 32'd1);
        chk("raw_pc_c2",  1, idpc[1], pc_mark);
        issue(32'h0);
        chk("raw_dil_c3", 1, 32'(dil[1]), 32'd0);
        chk("raw_exv_c3", 1, 32'(exv[1]), 32'd1);
        chk("raw_pc_c3",  1, idpc[1], pc_mark);
        pad(3);

        // r0 destinations never interlock
        issue(enc_i(6'h23, 5'd1, 5'd0, 16'h0004));
        issue(enc_r(5'd0, 5'd0, 5'd2));
        issue(32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("r0_ld_dil", i, 32'(dil[i]), 32'd0);
            chk("r0_ld_exv", i, 32'(exv[i]), 32'd1);
        end
        issue(enc_i(6'h08, 5'd1, 5'd0, 16'h0005));
        issue(enc_r(5'd0, 5'd0, 5'd2));
        issue(32'h0);
        for (int i = 0; i < 3; i++) chk("r0_addi_dil", i, 32'(dil[i]), 32'd0);
        pad(3);

        // branch during stall: flush wins
        issue(LW5);
        issue(ADD6);
        step(32'h0, 1'b1, 32'h40, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk("br_dil", i, 32'(dil[i]), 32'd0);
            chk("br_ibt", i, 32'(ibt[i]), 32'd1);
            chk("br_pc",  i, bpc[i], 32'h40);
            chk("br_exv", i, 32'(exv[i]), 32'd0);
        end
        issue(32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("br_next_exv", i, 32'(exv[i]), 32'd0);
            chk("br_next_dil", i, 32'(dil[i]), 32'd0);
        end
        pad(3);

        // reset mid-stall
        issue(LW5);
        issue(ADD6);
        step(32'h0, 1'b0, 32'h0, 1'b1);
        chk("rs_stalled", 0, 32'(dil[0]), 32'd1);
        issue(32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("rs_dil", i, 32'(dil[i]), 32'd0);
            chk("rs_exv", i, 32'(exv[i]), 32'd0);
            chk("rs_cnt", i, sc_of(i), 32'd0);
        end
        pad(2);

        // counter saturation: four load-use pairs
        for (int p = 0; p < 4; p++) begin
            issue(LW5);
            issue(ADD6);
            pad(2);
        end
        pad(2);
        chk("sat_cnt",   2, sc_of(2), 32'd3);
        chk("fwd_cnt",   0, sc_of(0), 32'd4);
        chk("nofwd_cnt", 1, sc_of(1), 32'd8);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [5:0]  op;
            logic [31:0] ir;
            case ($urandom_range(0, 5))
                0: op = 6'h00;
                1: op = 6'h08;
                2: op = 6'h23;
                3: op = 6'h2B;
                4: op = 6'h04;
                default: op = 6'h02;
            endcase
            ir = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 11'($urandom)};
            step(ir, ($urandom_range(0, 9) == 0), $urandom,
                 ($urandom_range(0, 99) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
